// File: rtl/synaptic_accumulator.sv
// Spike-event accumulator feeding the Izhikevich neuron core: buffers synapse
// events, looks up FP32 weights and sums them per timestep.

module fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        exc
);
  logic        a_big, sub, rb, special;
  logic [31:0] big, sml;
  logic [7:0]  eb, es, d, e_n;
  logic [26:0] mb, ms, ms_sh, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [30:0] res;

  always_comb begin
    a_big = (a[30:0] >= b[30:0]);
    big   = a_big ? a : b;
    sml   = a_big ? b : a;
    // Subnormals use exponent 1 with no hidden bit.
    eb    = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es    = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb    = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms    = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d     = eb - es;
    if (d >= 8'd27) begin
      ms_sh = {26'd0, |ms};
    end else begin
      ms_sh    = ms >> d;
      ms_sh[0] = ms_sh[0] | (|(ms & ~({27{1'b1}} << d)));
    end
    sub = big[31] ^ sml[31];
    sum = sub ? ({1'b0, mb} - {1'b0, ms_sh}) : ({1'b0, mb} + {1'b0, ms_sh});

    lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);

    e_n  = eb;
    norm = sum[26:0];
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e_n  = eb + 8'd1;
    end else if ({3'b000, lz} < eb) begin
      norm = sum[26:0] << lz;
      e_n  = eb - {3'b000, lz};
    end else begin
      norm = sum[26:0] << (eb - 8'd1);
      e_n  = 8'd0;
    end

    // Rounding carry ripples into the exponent field, covering the
    // subnormal->normal and max-finite->inf cases without extra logic.
    rb  = norm[2] & (norm[1] | norm[0] | norm[3]);
    res = {e_n, norm[25:3]} + {30'd0, rb};

    special = (big[30:23] == 8'hff) || (sml[30:23] == 8'hff);
    if (special) begin
      if ((big[30:23] == 8'hff && big[22:0] != 23'd0) ||
          (sml[30:23] == 8'hff && sml[22:0] != 23'd0) ||
          (sub && sml[30:23] == 8'hff))
        y = 32'h7fc00000;
      else
        y = {big[31], 8'hff, 23'd0};
    end else if (sum == 28'd0) begin
      y = {big[31] & sml[31], 31'd0};
    end else if (e_n == 8'hff) begin
      y = {big[31], 8'hff, 23'd0};
    end else begin
      y = {big[31], res};
    end
    exc = (y[30:23] == 8'hff);
  end
endmodule

module synaptic_accumulator #(
  parameter int NUM_SYN    = 16,
  parameter int SYN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SPIKE_VALID,
  input  logic [SYN_W-1:0] SPIKE_SRC,
  output logic             SPIKE_READY,
  input  logic             W_WE,
  input  logic [SYN_W-1:0] W_ADDR,
  input  logic [31:0]      W_DATA,
  input  logic             TIMESTEP,
  output logic [31:0]      I_OUT,
  output logic             I_VALID,
  output logic             ACC_EXC
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, ADD, PUBLISH} state_t;
  state_t state, state_nx;

  logic [31:0]      wram     [NUM_SYN];
  logic [SYN_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             pending, fifo_full, fifo_empty, push, pop;
  logic [31:0]      acc, w_reg, sum;
  logic             acc_exc_int, add_exc;

  assign fifo_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign SPIKE_READY = !fifo_full && !pending;
  assign push        = SPIKE_VALID && SPIKE_READY;

  fp32_add u_add (
    .a   (acc),
    .b   (w_reg),
    .y   (sum),
    .exc (add_exc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) state_nx = READ;
               else if (pending) state_nx = PUBLISH;
      READ:    state_nx = ADD;
      ADD:     begin
                 pop      = 1'b1;
                 state_nx = IDLE;
               end
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Weight RAM and FIFO storage are deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (W_WE) wram[W_ADDR] <= W_DATA;
    if (push) fifo_mem[wr_ptr] <= SPIKE_SRC;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      acc         <= '0;
      w_reg       <= '0;
      acc_exc_int <= 1'b0;
      I_OUT       <= '0;
      I_VALID     <= 1'b0;
      ACC_EXC     <= 1'b0;
    end else begin
      I_VALID <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (TIMESTEP && !pending) pending <= 1'b1;
      case (state)
        READ: w_reg <= wram[fifo_mem[rd_ptr]];
        ADD: begin
          acc         <= sum;
          acc_exc_int <= acc_exc_int | add_exc;
        end
        PUBLISH: begin
          I_OUT       <= acc;
          ACC_EXC     <= acc_exc_int;
          I_VALID     <= 1'b1;
          acc         <= '0;
          acc_exc_int <= 1'b0;
          pending     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_synaptic_accumulator.sv
// Scoreboard bench for synaptic_accumulator: directed spike/timestep vectors,
// expected publishes queued at stimulus time and checked by a monitor.
module tb_synaptic_accumulator;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SPIKE_VALID = 1'b0;
  logic [3:0]  SPIKE_SRC = '0;
  logic        SPIKE_READY;
  logic        W_WE = 1'b0;
  logic [3:0]  W_ADDR = '0;
  logic [31:0] W_DATA = '0;
  logic        TIMESTEP = 1'b0;
  logic [31:0] I_OUT;
  logic        I_VALID;
  logic        ACC_EXC;

  synaptic_accumulator #(.NUM_SYN(16), .SYN_W(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .SPIKE_VALID(SPIKE_VALID), .SPIKE_SRC(SPIKE_SRC),
    .SPIKE_READY(SPIKE_READY), .W_WE(W_WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .TIMESTEP(TIMESTEP), .I_OUT(I_OUT), .I_VALID(I_VALID), .ACC_EXC(ACC_EXC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (I_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_i_valid: got pulse with I_OUT=%h, required none (cycle %0d)", I_OUT, cyc);
      end else begin
        e = sb.pop_front();
        chk("i_out", I_OUT, e.data);
        chk("acc_exc", {31'd0, ACC_EXC}, {31'd0, e.exc});
        if (e.due != 0) chk("publish_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_w(input logic [3:0] a, input logic [31:0] d);
    W_WE = 1'b1; W_ADDR = a; W_DATA = d;
    tick();
    W_WE = 1'b0;
  endtask

  task automatic spike(input logic [3:0] src);
    bit done = 0;
    SPIKE_VALID = 1'b1; SPIKE_SRC = src;
    for (int i = 0; i < 50 && !done; i++) begin
      if (SPIKE_READY) done = 1;
      tick();
    end
    SPIKE_VALID = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL spike_accept: src %0d not accepted within 50 cycles", src);
    end
  endtask

  task automatic expect_pub(input logic [31:0] d, input logic x, input int due);
    exp_t e;
    e.data = d; e.exc = x; e.due = due;
    sb.push_back(e);
  endtask

  task automatic timestep();
    TIMESTEP = 1'b1;
    tick();
    TIMESTEP = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d publishes outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    bit saw_low;
    repeat (2) tick();
    RESET = 1'b0;

    // Reset state and empty-step publish latency.
    chk("reset_i_out", I_OUT, 32'h0);
    chk("reset_i_valid", {31'd0, I_VALID}, 32'd0);
    chk("reset_acc_exc", {31'd0, ACC_EXC}, 32'd0);
    chk("reset_ready", {31'd0, SPIKE_READY}, 32'd1);
    expect_pub(32'h00000000, 1'b0, cyc + 3);
    timestep();
    drain();

    // 1.0 + 2.5 - 0.5 = 3.0
    wr_w(4'd1, 32'h3f800000);
    wr_w(4'd2, 32'h40200000);
    wr_w(4'd3, 32'hbf000000);
    spike(4'd1); spike(4'd2); spike(4'd3);
    expect_pub(32'h40400000, 1'b0, 0);
    timestep();
    drain();

    // Hold src 2 for 8 cycles from idle: accepts on edges 1-5 and 8 -> 6 x 2.5.
    acc_cnt = 0; saw_low = 0;
    SPIKE_VALID = 1'b1; SPIKE_SRC = 4'd2;
    for (int i = 0; i < 8; i++) begin
      if (SPIKE_READY) acc_cnt++;
      else saw_low = 1;
      tick();
    end
    SPIKE_VALID = 1'b0;
    chk("hold_accepted", acc_cnt, 6);
    chk("hold_ready_dropped", {31'd0, saw_low}, 32'd1);
    expect_pub(32'h41700000, 1'b0, 0);
    timestep();
    drain();
    for (int i = 0; i < 5; i++) spike(4'd2);
    expect_pub(32'h41480000, 1'b0, 0);
    timestep();
    drain();

    // Spike on the TIMESTEP edge belongs to this step; re-pulse ignored.
    SPIKE_VALID = 1'b1; SPIKE_SRC = 4'd1; TIMESTEP = 1'b1;
    chk("ts_spike_ready", {31'd0, SPIKE_READY}, 32'd1);
    expect_pub(32'h3f800000, 1'b0, cyc + 6);
    tick();
    SPIKE_VALID = 1'b0; TIMESTEP = 1'b0;
    chk("pending_ready_low", {31'd0, SPIKE_READY}, 32'd0);
    tick();
    TIMESTEP = 1'b1;
    tick();
    TIMESTEP = 1'b0;
    chk("pending_ready_low2", {31'd0, SPIKE_READY}, 32'd0);
    drain();
    chk("ready_after_publish", {31'd0, SPIKE_READY}, 32'd1);

    // Overflow: max finite + max finite -> +inf with exception; next step clean.
    wr_w(4'd4, 32'h7f7fffff);
    spike(4'd4); spike(4'd4);
    expect_pub(32'h7f800000, 1'b1, 0);
    timestep();
    drain();
    expect_pub(32'h00000000, 1'b0, 0);
    timestep();
    drain();

    // Make I_OUT non-zero so the reset check below is meaningful.
    spike(4'd1);
    expect_pub(32'h3f800000, 1'b0, 0);
    timestep();
    drain();

    // RESET while the engine is in READ discards buffered events.
    spike(4'd1); spike(4'd2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midreset_i_out", I_OUT, 32'h0);
    chk("midreset_ready", {31'd0, SPIKE_READY}, 32'd1);
    expect_pub(32'h00000000, 1'b0, cyc + 3);
    timestep();
    drain();
    spike(4'd2);
    expect_pub(32'h40200000, 1'b0, 0);
    timestep();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
